// File: rtl/seq_divider.sv
// seq_divider: multi-cycle RV32M divider (DIV/DIVU/REM/REMU), restoring algorithm.
// Ports: clk, rst (async, active-high), start/a/b/op request, busy/done/result status.
// Build option: define SEQ_DIVIDER_EARLY_TERM_EN to finish |a|<|b| in one edge.
module seq_divider #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   op,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [N-1:0] MIN = {1'b1, {(N-1){1'b0}}};

  state_t state, state_n;

  logic [N:0]   rem;
  logic [N-1:0] quo;
  logic [N-1:0] dvs;
  logic [4:0]   cnt;
  logic         rem_op;
  logic         neg_q;
  logic         neg_r;

  logic         accept;
  logic         sgn;
  logic         is_rem;
  logic         a_neg;
  logic         b_neg;
  logic [N-1:0] a_mag;
  logic [N-1:0] b_mag;
  logic         div0;
  logic         ovf;
  logic         early;
  logic         special;
  logic [N-1:0] spec_res;
  logic [N:0]   shifted;
  logic [N:0]   diff;
  logic [N-1:0] q_fin;
  logic [N-1:0] r_fin;

  assign accept = start & ((state == IDLE) | (state == DONE));
  assign sgn    = ~op[0];
  assign is_rem = op[1];
  assign a_neg  = sgn & a[N-1];
  assign b_neg  = sgn & b[N-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;
  assign div0   = (b == '0);
  assign ovf    = sgn & (a == MIN) & (b == '1);

`ifdef SEQ_DIVIDER_EARLY_TERM_EN
  assign early  = ~div0 & (a_mag < b_mag);
`else
  assign early  = 1'b0;
`endif

  assign special = div0 | ovf | early;

  // Quotient is all-ones on divide-by-zero; the remainder is the raw dividend.
  always_comb begin
    spec_res = '0;
    if (div0)
      spec_res = is_rem ? a : '1;
    else if (ovf)
      spec_res = is_rem ? '0 : MIN;
    else
      spec_res = is_rem ? a : '0;
  end

  // One restoring step: shift in the next dividend bit, trial-subtract.
  assign shifted = {rem[N-1:0], quo[N-1]};
  assign diff    = shifted - {1'b0, dvs};

  assign q_fin = neg_q ? -quo : quo;
  assign r_fin = neg_r ? -rem[N-1:0] : rem[N-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept)
          state_n = special ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == 5'd31)
          state_n = FIX;
      end
      FIX: begin
        busy    = 1'b1;
        state_n = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (accept)
          state_n = special ? DONE : CALC;
        else
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      cnt    <= '0;
      rem_op <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else if (accept) begin
      rem    <= '0;
      quo    <= a_mag;
      dvs    <= b_mag;
      cnt    <= '0;
      rem_op <= is_rem;
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      if (special)
        result <= spec_res;
    end else if (state == CALC) begin
      cnt <= cnt + 5'd1;
      if (!diff[N]) begin
        rem <= diff;
        quo <= {quo[N-2:0], 1'b1};
      end else begin
        rem <= shifted;
        quo <= {quo[N-2:0], 1'b0};
      end
    end else if (state == FIX) begin
      result <= rem_op ? r_fin : q_fin;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed + randomized checks of seq_divider against
// an arithmetic reference model (values and completion latency).
module tb_seq_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  op;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_tests;
  int n_fail;

  seq_divider #(.N(32)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a(a),
    .b(b),
    .op(op),
    .busy(busy),
    .done(done),
    .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [1:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
    int sx;
    int sy;
    sx = x;
    sy = y;
    if (y == 0)
      return o[1] ? x : 32'hFFFF_FFFF;
    if (!o[0]) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
        return o[1] ? 32'h0 : 32'h8000_0000;
      return o[1] ? 32'(sx % sy) : 32'(sx / sy);
    end
    return o[1] ? x % y : x / y;
  endfunction

  function automatic int ref_lat(input logic [1:0] o,
                                 input logic [31:0] x,
                                 input logic [31:0] y);
    longint ax;
    longint ay;
    if (y == 0)
      return 1;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
      return 1;
    ax = o[0] ? longint'(x) : longint'($signed(x));
    ay = o[0] ? longint'(y) : longint'($signed(y));
    if (ax < 0) ax = -ax;
    if (ay < 0) ay = -ay;
`ifdef SEQ_DIVIDER_EARLY_TERM_EN
    if (ax < ay)
      return 1;
`endif
    return 34;
  endfunction

  // Issue one op; edges are counted with the accepting edge as edge 1.
  task automatic run(input string tag, input logic [1:0] o,
                     input logic [31:0] x, input logic [31:0] y,
                     input int rep, input bit chain);
    logic [31:0] exp_r;
    logic [31:0] r0;
    int          exp_lat;
    int          k;
    int          nbusy;
    bit          stable;
    bit          both;
    exp_r   = ref_res(o, x, y);
    exp_lat = ref_lat(o, x, y);
    if (!chain)
      @(negedge clk);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    op    = 2'($urandom);
    k      = 1;
    nbusy  = 0;
    stable = 1'b1;
    both   = 1'b0;
    r0     = result;
    while (!done && k < 60) begin
      if (busy) nbusy++;
      if (busy && result !== r0) stable = 1'b0;
      if (k == rep) begin
        start = 1'b1;
        b     = $urandom | 32'h1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      k++;
      if (busy && done) both = 1'b1;
    end
    start = 1'b0;
    check({tag, "_lat"}, 32'(k), 32'(exp_lat));
    check({tag, "_res"}, result, exp_r);
    check({tag, "_busy"}, 32'(nbusy), (exp_lat == 1) ? 32'd0 : 32'd33);
    check({tag, "_stable"}, 32'(stable), 32'd1);
    check({tag, "_excl"}, 32'(both), 32'd0);
    if (!chain) begin
      @(posedge clk);
      #1;
      check({tag, "_done1"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] x;
    logic [31:0] y;
    logic [1:0]  o;
    int          seen;
    n_tests = 0;
    n_fail  = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    op    = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_res", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run("div20_3", 2'b00, 32'd20, 32'd3, 0, 1'b0);
    run("rem_m20", 2'b10, 32'hFFFF_FFEC, 32'd3, 0, 1'b0);
    run("remu_m20", 2'b11, 32'hFFFF_FFEC, 32'd3, 0, 1'b0);
    run("divu_z", 2'b01, 32'd7, 32'd0, 0, 1'b0);
    run("rem_z", 2'b10, 32'd7, 32'd0, 0, 1'b0);
    run("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run("repulse", 2'b00, 32'd1000, 32'hFFFF_FFF9, 10, 1'b0);
    run("chain_a", 2'b01, 32'd99, 32'd5, 0, 1'b1);
    run("chain_b", 2'b11, 32'd99, 32'd0, 0, 1'b1);
    run("chain_c", 2'b00, 32'hFFFF_FF9C, 32'd9, 0, 1'b0);
    run("small", 2'b10, 32'd3, 32'hFFFF_FFF0, 0, 1'b0);

    // Reset in the middle of CALC abandons the operation.
    @(negedge clk);
    op    = 2'b01;
    a     = 32'd5000;
    b     = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_res", result, 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check("midrst_nodone", 32'(seen), 32'd0);
    run("divu100_7", 2'b01, 32'd100, 32'd7, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      x = $urandom;
      y = $urandom;
      unique case (i % 5)
        0: y = 32'($urandom_range(1, 20));
        1: y = 32'h0;
        2: y = -32'($urandom_range(1, 20));
        3: begin
          x = 32'h8000_0000;
          y = 32'hFFFF_FFFF;
        end
        default: y = y >> $urandom_range(0, 31);
      endcase
      run("rand", o, x, y, 0, 1'(i % 7 == 3));
    end

    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
